mul_seq: RTL and testbench
==========================

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter W, default 4, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a multiply; sampled on rising edge of clk.
REQ-005 SHALL have port sgn  input  1  mode: 0 = unsigned, 1 = two's-complement signed; sampled with start.
REQ-006 SHALL have port a  input  W  multiplicand; sampled with start.
REQ-007 SHALL have port b  input  W  multiplier; sampled with start.
REQ-008 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; p valid in this cycle.
REQ-010 SHALL have port p  output  2W  product; held stable until the next completion.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-012 SHALL accept start only in IDLE or DONE; on acceptance latch a, b, sgn, clear the accumulator and iteration counter, and enter CALC.
REQ-013 SHALL ignore start (no effect on operands, counter or outputs) while in CALC.
REQ-014 SHALL, in CALC, perform one shift-add step per cycle (one multiplier bit per cycle, LSB first) for exactly W cycles.
REQ-015 SHALL, in signed mode, multiply operand magnitudes and negate the 2W-bit result iff exactly one operand is negative; -2^(W-1) operands SHALL be handled (magnitude 2^(W-1) held in W+1 bits or equivalent).
REQ-016 SHALL, in unsigned mode, treat a and b as unsigned; the product SHALL never overflow 2W bits.
REQ-017 SHALL assert busy in every CALC cycle and only then.
REQ-018 SHALL, on the edge ending the W-th CALC cycle, load p with the final product and enter DONE.
REQ-019 SHALL assert done exactly for the single DONE cycle; done and busy SHALL never be high together.
REQ-020 SHALL latency: start accepted at edge n -> busy high after edges n..n+W-1, p updated and done high after edge n+W.
REQ-021 SHALL leave DONE for CALC if start is high at the DONE-exit edge (back-to-back, no idle cycle), else for IDLE.
REQ-022 SHALL keep p unchanged from one completion until the next completion, including through IDLE and CALC.
REQ-023 SHALL use an iteration counter of ceil(log2(W+1)) bits with no wrap-around during a multiply.
REQ-024 SHALL produce a result independent of changes on a, b, sgn after the accepting edge.

Reset
REQ-025 SHALL, when rst_n is low, immediately (without a clock) force state IDLE, busy=0, done=0, p=0, counter and accumulator 0.
REQ-026 SHALL abort any in-progress multiply on reset; no done pulse SHALL follow for the aborted operation.
REQ-027 SHALL ignore start on the first rising edge coinciding with rst_n low; after rst_n rises, start on the next edge SHALL be accepted normally.

Verification (W=4)
REQ-028 SHALL verify unsigned: sgn=0, a=4'b1101, b=4'b1011, start 1 cycle -> busy 4 cycles, then done 1 cycle with p=8'b10001111 (143).
REQ-029 SHALL verify signed: sgn=1, a=4'b1101 (-3), b=4'b0101 -> p=8'hF1 (-15); a=b=4'b1000 (-8) -> p=8'h40 (64).
REQ-030 SHALL verify bounds: sgn=0, a=b=4'hF -> p=8'hE1; a=0, b=4'h9 -> p=8'h00 with done still pulsed.
REQ-031 SHALL verify start held high continuously through a CALC with changing a/b -> first result uses operands at accept edge; second operation starts directly from DONE.
REQ-032 SHALL verify rst_n pulsed low in 2nd CALC cycle -> busy=0, done=0, p=0 immediately; no done pulse until a new start.
REQ-033 SHALL verify p unchanged (previous product) throughout a following operation's busy cycles until its done.

Source files
------------

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, unsigned or
// two's-complement signed (sign-magnitude around an unsigned core).
module mul_seq #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           sgn,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]   p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;

  logic [W-1:0]     mag_a, mag_b;
  logic [2*W-1:0]   sum;

  always_comb begin
    // Magnitude of -2^(W-1) is 2^(W-1), which still fits W unsigned bits.
    mag_a = (sgn && a[W-1]) ? (~a + 1'b1) : a;
    mag_b = (sgn && b[W-1]) ? (~b + 1'b1) : b;
    sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d  = {{W{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = sgn & (a[W-1] ^ b[W-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          p_d     = neg_q ? -sum : sum;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  assign busy = (state_q == S_CALC);
  assign done = (state_q == S_DONE);
  assign p    = p_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq (W=4): directed corner cases, back-to-back,
// reset abort, then randomized operations against an integer reference model.
module tb_mul_seq;
  localparam int unsigned W  = 4;
  localparam int unsigned PW = 2 * W;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sgn;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [PW-1:0] p;

  int unsigned   n_vec;
  int unsigned   n_err;
  logic [PW-1:0] p_prev;

  mul_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] model(input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
    longint xi;
    longint yi;
    xi = longint'(x);
    yi = longint'(y);
    if (s && x[W-1]) xi = xi - (longint'(1) << W);
    if (s && y[W-1]) yi = yi - (longint'(1) << W);
    return PW'(xi * yi);
  endfunction

  // Called at a negedge; start is raised for the next edge. With hold=1 start
  // stays high, so the following do_op is accepted straight out of DONE.
  task automatic do_op(input bit s, input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    logic [PW-1:0] exp;
    exp   = model(s, x, y);
    sgn   = s;
    a     = x;
    b     = y;
    start = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      @(negedge clk);
      start = hold;
      a     = W'($urandom);
      b     = W'($urandom);
      sgn   = 1'($urandom);
      check("busy_calc", 64'(busy), 64'd1);
      check("done_calc", 64'(done), 64'd0);
      check("p_hold",    64'(p),    64'(p_prev));
    end
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd1);
    check("busy_done",  64'(busy), 64'd0);
    check("product",    64'(p),    64'(exp));
    p_prev = exp;
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("busy_idle", 64'(busy), 64'd0);
      check("done_idle", 64'(done), 64'd0);
      check("p_idle",    64'(p),    64'(p_prev));
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    p_prev = '0;
    rst_n  = 1'b0;
    start  = 1'b1;
    sgn    = 1'b0;
    a      = 4'h7;
    b      = 4'h7;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_p",    64'(p),    64'd0);

    // start high across an edge while in reset must be ignored
    @(negedge clk);
    check("rst_start_ign", 64'(busy), 64'd0);
    rst_n = 1'b1;

    do_op(1'b0, 4'b1101, 4'b1011, 1'b0);   // 143
    idle_cycles(2);
    do_op(1'b1, 4'b1101, 4'b0101, 1'b0);   // -15
    do_op(1'b1, 4'b1000, 4'b1000, 1'b0);   // 64, back-to-back from DONE
    idle_cycles(1);
    do_op(1'b0, 4'hF, 4'hF, 1'b0);         // E1
    idle_cycles(1);
    do_op(1'b0, 4'h0, 4'h9, 1'b0);         // 00, done still pulsed
    idle_cycles(1);

    do_op(1'b0, 4'h6, 4'h7, 1'b1);
    do_op(1'b1, 4'h9, 4'h3, 1'b0);
    idle_cycles(2);

    // abort in the second CALC cycle
    sgn = 1'b0; a = 4'hB; b = 4'hD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy1", 64'(busy), 64'd1);
    @(negedge clk);
    check("abort_busy2", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_p",    64'(p),    64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    p_prev = '0;
    idle_cycles(W + 3);

    for (int unsigned k = 0; k < 60; k++) begin
      do_op(1'($urandom), W'($urandom), W'($urandom), 1'b0);
      idle_cycles($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
